// File: rtl/flounder_pkg.sv
// Shared definitions for the Flounder Z180 glue block.
package flounder_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;

  localparam int unsigned STAT_NOT_EMPTY = 0;
  localparam int unsigned STAT_FULL      = 1;
  localparam int unsigned STAT_OVERFLOW  = 2;
  localparam int unsigned STAT_FRAME_ERR = 3;
  localparam int unsigned STAT_IRQ_EN    = 7;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_e;

endpackage

// File: rtl/flounder_ps2_rx.sv
// PS/2 frame receiver: synchronisers, falling-edge detect, frame FSM and timeout.
module flounder_ps2_rx
  import flounder_pkg::*;
#(
  parameter int unsigned KB_TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       kb_clk,
  input  logic       kb_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err
);

  localparam int unsigned    TW       = $clog2(KB_TIMEOUT + 1);
  localparam logic [TW-1:0]  TMO_LAST = TW'(KB_TIMEOUT - 1);

  ps2_state_e     state_q, state_d;
  logic [1:0]     kbc_sync_q, kbc_sync_d;
  logic [1:0]     kbd_sync_q, kbd_sync_d;
  logic           kbc_prev_q, kbc_prev_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [7:0]     byte_q, byte_d;
  logic           valid_q, valid_d;
  logic           err_q, err_d;
  logic           fall;
  logic           kbd;

  always_comb begin
    kbc_sync_d = {kbc_sync_q[0], kb_clk};
    kbd_sync_d = {kbd_sync_q[0], kb_data};
    kbc_prev_d = kbc_sync_q[1];
    fall       = kbc_prev_q & ~kbc_sync_q[1];
    kbd        = kbd_sync_q[1];
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    tmo_d      = tmo_q;
    byte_d     = byte_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    if (fall) begin
      tmo_d = '0;
      unique case (state_q)
        IDLE: begin
          if (!kbd) begin
            state_d   = DATA;
            bit_cnt_d = '0;
            par_d     = 1'b0;
          end
        end
        DATA: begin
          shift_d = {kbd, shift_q[7:1]};
          par_d   = par_q ^ kbd;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
          else                   bit_cnt_d = bit_cnt_q + 3'd1;
        end
        PARITY: begin
          // par_q ends up 1 when data plus parity carry an odd number of ones
          par_d   = par_q ^ kbd;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (par_q && kbd) begin
            valid_d = 1'b1;
            byte_d  = shift_q;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      if (tmo_q == TMO_LAST) begin
        state_d   = IDLE;
        tmo_d     = '0;
        bit_cnt_d = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      kbc_sync_q <= '1;
      kbd_sync_q <= '1;
      kbc_prev_q <= 1'b1;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tmo_q      <= '0;
      byte_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      kbc_sync_q <= kbc_sync_d;
      kbd_sync_q <= kbd_sync_d;
      kbc_prev_q <= kbc_prev_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tmo_q      <= tmo_d;
      byte_q     <= byte_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign rx_byte  = byte_q;
  assign rx_valid = valid_q;
  assign rx_err   = err_q;

endmodule

// File: rtl/flounder_glue.sv
// Z180 glue: memory decode, CPLD register window, scan-code FIFO and keyboard interrupt.
module flounder_glue
  import flounder_pkg::*;
#(
  parameter int unsigned ROM_BLOCKS   = 4,
  parameter int unsigned RAM_BASE_BLK = 4,
  parameter int unsigned RAM_BLOCKS   = 2,
  parameter int unsigned CPLD_BLK     = 6,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned KB_TIMEOUT   = 4096
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       MREQ,
  input  logic       IOREQ,
  input  logic       R,
  input  logic       W,
  input  logic [6:0] A,
  input  logic [1:0] AL,
  input  logic       KB_CLK,
  input  logic       KB_DATA,
  inout  logic [7:0] D,
  output logic       ROMEN,
  output logic       RAMEN,
  output logic       RAMWR,
  output logic       INT
);

  localparam int unsigned PW      = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_L = (PW + 1)'(FIFO_DEPTH);
  localparam logic [7:0]  ROM_END = 8'(ROM_BLOCKS);
  localparam logic [7:0]  RAM_LO  = 8'(RAM_BASE_BLK);
  localparam logic [7:0]  RAM_HI  = 8'(RAM_BASE_BLK + RAM_BLOCKS);
  localparam logic [6:0]  WIN_BLK = 7'(CPLD_BLK);

  if (RAM_BLOCKS != 0 && RAM_BASE_BLK < ROM_BLOCKS) begin : g_err_rom_ram
    $error("flounder_glue: ROM and RAM regions overlap");
  end
  if (CPLD_BLK < ROM_BLOCKS) begin : g_err_rom_cpld
    $error("flounder_glue: register window overlaps ROM");
  end
  if (CPLD_BLK >= RAM_BASE_BLK && CPLD_BLK < RAM_BASE_BLK + RAM_BLOCKS) begin : g_err_ram_cpld
    $error("flounder_glue: register window overlaps RAM");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_err_depth
    $error("flounder_glue: FIFO_DEPTH must be a power of 2 in 2..16");
  end

  logic [7:0]  rx_byte;
  logic        rx_valid, rx_err;
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [7:0]  mem_d [FIFO_DEPTH];
  logic [PW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
  logic        ovf_q, ovf_d, ferr_q, ferr_d, irq_en_q, irq_en_d;
  logic        rd_pend_q, rd_pend_d, wr_pend_q, wr_pend_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        int_n_q, int_n_d;
  logic        win_sel, rd_act, wr_act, pop, push, not_empty, full;
  logic [7:0]  status, rd_data;
  logic        unused_ioreq;

  assign unused_ioreq = IOREQ;

  flounder_ps2_rx #(.KB_TIMEOUT(KB_TIMEOUT)) u_rx (
    .clk      (CLK),
    .rst      (RST),
    .kb_clk   (KB_CLK),
    .kb_data  (KB_DATA),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_err   (rx_err)
  );

  always_comb begin
    ROMEN   = ~(~MREQ & ~R & ({1'b0, A} < ROM_END));
    RAMEN   = ~(~MREQ & ({1'b0, A} >= RAM_LO) & ({1'b0, A} < RAM_HI));
    RAMWR   = W;
    win_sel = ~MREQ & (A == WIN_BLK);
  end

  always_comb begin
    count     = wr_ptr_q - rd_ptr_q;
    not_empty = (count != '0);
    full      = (count == DEPTH_L);
    status                 = '0;
    status[STAT_NOT_EMPTY] = not_empty;
    status[STAT_FULL]      = full;
    status[STAT_OVERFLOW]  = ovf_q;
    status[STAT_FRAME_ERR] = ferr_q;
    status[STAT_IRQ_EN]    = irq_en_q;
    unique case (AL)
      REG_DATA:   rd_data = not_empty ? mem_q[rd_ptr_q[PW-1:0]] : 8'h00;
      REG_STATUS: rd_data = status;
      default:    rd_data = 8'h00;
    endcase
  end

  assign D = (win_sel && !R) ? rd_data : 'z;

  always_comb begin
    // Bus accesses are latched while the strobe is low and acted on once it rises.
    rd_act    = win_sel & ~R & (AL == REG_DATA);
    wr_act    = win_sel & ~W & (AL == REG_STATUS);
    rd_pend_d = rd_act & (rd_pend_q | not_empty);
    pop       = rd_pend_q & ~rd_act;
    wr_pend_d = wr_act;
    wr_data_d = wr_act ? D : wr_data_q;
    push      = rx_valid & (~full | pop);

    ovf_d    = ovf_q;
    ferr_d   = ferr_q;
    irq_en_d = irq_en_q;
    if (wr_pend_q && !wr_act) begin
      irq_en_d = wr_data_q[STAT_IRQ_EN];
      if (wr_data_q[STAT_OVERFLOW])  ovf_d  = 1'b0;
      if (wr_data_q[STAT_FRAME_ERR]) ferr_d = 1'b0;
    end
    if (rx_err)                  ferr_d = 1'b1;
    if (rx_valid && full && !pop) ovf_d = 1'b1;

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q[PW-1:0]] = rx_byte;
    wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, pop};
    int_n_d  = ~(irq_en_q & not_empty);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mem_q     <= '{default: '0};
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ovf_q     <= 1'b0;
      ferr_q    <= 1'b0;
      irq_en_q  <= 1'b0;
      rd_pend_q <= 1'b0;
      wr_pend_q <= 1'b0;
      wr_data_q <= '0;
      int_n_q   <= 1'b1;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ovf_q     <= ovf_d;
      ferr_q    <= ferr_d;
      irq_en_q  <= irq_en_d;
      rd_pend_q <= rd_pend_d;
      wr_pend_q <= wr_pend_d;
      wr_data_q <= wr_data_d;
      int_n_q   <= int_n_d;
    end
  end

  assign INT = int_n_q;

endmodule
